// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, skid buffer, stall/flush/redirect.
// Optional macro FETCH_PERF_EN adds saturating fetch and bubble counters.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            global_reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t state_q, state_d;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_data_q, skid_data_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;

    logic do_redirect;
    logic do_flush;
    logic do_stall;

    // Redirect is ignored in IDLE; flush and stall only apply when nothing above them fires.
    assign do_redirect = (state_q != IDLE) && redirect_valid;
    assign do_flush    = flush_i && !do_redirect;
    assign do_stall    = stall_i && !do_redirect && !do_flush;

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN,
            HOLD: begin
                if (do_redirect || do_flush) begin
                    state_d = RUN;
                end else if (do_stall) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state_q != IDLE) && !redirect_valid && !flush_i && !stall_i;
        imem_addr = pc_q & ALIGN_MASK;
    end

    always_comb begin
        pc_d             = pc_q;
        req_valid_d      = req_valid_q;
        req_pc_d         = req_pc_q;
        skid_valid_d     = skid_valid_q;
        skid_data_d      = skid_data_q;
        skid_pc_d        = skid_pc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;

        if (do_redirect || do_flush) begin
            req_valid_d   = 1'b0;
            skid_valid_d  = 1'b0;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            if (do_redirect) begin
                pc_d = redirect_pc & ALIGN_MASK;
            end
        end else if (do_stall) begin
            // Park the response that lands while Decode is stalled.
            if (req_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = imem_rdata;
                skid_pc_d    = req_pc_q;
                req_valid_d  = 1'b0;
            end
        end else begin
            if (skid_valid_q) begin
                if_id_valid_d    = 1'b1;
                if_id_instr_d    = skid_data_q;
                if_id_pc_d       = skid_pc_q;
                if_id_pc_plus4_d = skid_pc_q + FOUR;
                skid_valid_d     = 1'b0;
            end else if (req_valid_q) begin
                if_id_valid_d    = 1'b1;
                if_id_instr_d    = imem_rdata;
                if_id_pc_d       = req_pc_q;
                if_id_pc_plus4_d = req_pc_q + FOUR;
            end else begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
            req_valid_d = imem_req;
            if (imem_req) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + FOUR;
            end
        end
    end

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            pc_q             <= RESET_PC;
            req_valid_q      <= 1'b0;
            req_pc_q         <= '0;
            skid_valid_q     <= 1'b0;
            skid_data_q      <= '0;
            skid_pc_q        <= '0;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
        end else begin
            pc_q             <= pc_d;
            req_valid_q      <= req_valid_d;
            req_pc_q         <= req_pc_d;
            skid_valid_q     <= skid_valid_d;
            skid_data_q      <= skid_data_d;
            skid_pc_q        <= skid_pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;

    // A bubble is counted only when IF/ID is actually reloaded with an empty slot.
    always_comb begin
        perf_fetch_cnt_d  = perf_fetch_cnt_q;
        perf_bubble_cnt_d = perf_bubble_cnt_q;
        if (imem_req && (perf_fetch_cnt_q != 32'hFFFF_FFFF)) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end
        if (!do_stall && !if_id_valid_d && !stall_i && (perf_bubble_cnt_q != 32'hFFFF_FFFF)) begin
            perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            perf_fetch_cnt_q  <= '0;
            perf_bubble_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q  <= perf_fetch_cnt_d;
            perf_bubble_cnt_q <= perf_bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_cnt_q;
    assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (main instance plus wrap-around instance).
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] plus4;
    } exp_t;

    logic        clk = 1'b0;
    logic        global_reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        stall_i, flush_i, redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;

    logic        rst2_n;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic        tie_lo = 1'b0;
    logic [31:0] tie_pc = '0;
    logic        if_id_valid2;
    logic [31:0] if_id_instr2, if_id_pc2, if_id_pc_plus4_2;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt, perf_fetch_cnt2, perf_bubble_cnt2;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .global_reset   (global_reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .global_reset   (rst2_n),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .stall_i        (tie_lo),
        .flush_i        (tie_lo),
        .redirect_valid (tie_lo),
        .redirect_pc    (tie_pc),
        .if_id_valid    (if_id_valid2),
        .if_id_instr    (if_id_instr2),
        .if_id_pc       (if_id_pc2),
        .if_id_pc_plus4 (if_id_pc_plus4_2)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt2),
        .perf_bubble_cnt(perf_bubble_cnt2)
`endif
    );

    // Synchronous instruction memory: mem[a] = a ^ 32'hA5A5_0000, one cycle latency.
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= imem_addr  ^ 32'hA5A5_0000;
        if (imem_req2) imem_rdata2 <= imem_addr2 ^ 32'hA5A5_0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'hA5A5_0000;
        e.plus4 = pc + 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_imem_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_imem_addr"},  imem_addr,            32'h0);
        chk({tag, "_valid"},      {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_instr"},      if_id_instr,          32'h0000_0013);
        chk({tag, "_pc"},         if_id_pc,             32'h0);
        chk({tag, "_pc_plus4"},   if_id_pc_plus4,       32'h0);
    endtask

    // Decode consumes IF/ID when it is valid and neither stalled nor flushed.
    always @(negedge clk) begin
        if (global_reset && if_id_valid && !stall_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_instr actual pc=%h required=none", if_id_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_pc",    if_id_pc,       e.pc);
                chk("mon_instr", if_id_instr,    e.instr);
                chk("mon_plus4", if_id_pc_plus4, e.plus4);
            end
        end
    end

    always @(negedge clk) begin
        if (rst2_n && if_id_valid2 && exp2_q.size() > 0) begin
            exp_t e;
            e = exp2_q.pop_front();
            chk("wrap_pc",    if_id_pc2,        e.pc);
            chk("wrap_instr", if_id_instr2,     e.instr);
            chk("wrap_plus4", if_id_pc_plus4_2, e.plus4);
        end
    end

    initial begin
        exp2_q.push_back('{pc: 32'hFFFF_FFF8, instr: 32'h5A5A_FFF8, plus4: 32'hFFFF_FFFC});
        exp2_q.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h5A5A_FFFC, plus4: 32'h0000_0000});
        exp2_q.push_back('{pc: 32'h0000_0000, instr: 32'hA5A5_0000, plus4: 32'h0000_0004});
        rst2_n = 1'b1;
        #1 rst2_n = 1'b0;
        repeat (2) step();
        rst2_n = 1'b1;
    end

    initial begin
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        global_reset   = 1'b1;
        #1 global_reset = 1'b0;
        repeat (2) step();
        check_reset("rst");

        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        global_reset = 1'b1;
        step();
        chk("idle_valid", {31'd0, if_id_valid}, 32'd0);
        #1;
        chk("run_req",  {31'd0, imem_req}, 32'd1);
        chk("run_addr", imem_addr,         32'h0);
        step();
        chk("e2_valid", {31'd0, if_id_valid}, 32'd0);
        chk("e2_addr",  imem_addr,            32'h4);
        step();
        chk("e3_valid", {31'd0, if_id_valid}, 32'd1);

        step();
        stall_i = 1'b1;
        #1 chk("stall_req0", {31'd0, imem_req}, 32'd0);
        step();
        chk("stall_hold1", if_id_pc, 32'h4);
        #1 chk("stall_req1", {31'd0, imem_req}, 32'd0);
        step();
        chk("stall_hold2", if_id_pc, 32'h4);
        stall_i = 1'b0;
        step();
        chk("unstall_pc",   if_id_pc,  32'h8);
        chk("unstall_addr", imem_addr, 32'h10);

        step();
        push(32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1 chk("redir_req", {31'd0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_instr", if_id_instr,          32'h0000_0013);
        #1;
        chk("redir_addr", imem_addr,         32'h100);
        chk("redir_req2", {31'd0, imem_req}, 32'd1);
        step();
        chk("redir_bubble2", {31'd0, if_id_valid}, 32'd0);
        step();

        step();
        stall_i = 1'b1;
        step();
        push(32'h200);
        flush_i        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1 chk("combo_req", {31'd0, imem_req}, 32'd0);
        step();
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        redirect_valid = 1'b0;
        chk("combo_valid", {31'd0, if_id_valid}, 32'd0);
        chk("combo_instr", if_id_instr,          32'h0000_0013);
        #1 chk("combo_addr", imem_addr, 32'h200);
        step();
        chk("skid_cleared", {31'd0, if_id_valid}, 32'd0);
        step();

        step();
        push(32'h20C);
        flush_i = 1'b1;
        #1 chk("flush_req", {31'd0, imem_req}, 32'd0);
        step();
        flush_i = 1'b0;
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        #1 chk("flush_addr", imem_addr, 32'h20C);
        step();
        step();
        step();

        global_reset = 1'b0;
        #1 check_reset("midrst");
        push(32'h0); push(32'h4); push(32'h8);
        repeat (2) step();
        global_reset = 1'b1;
        step();
        chk("re_idle_valid", {31'd0, if_id_valid}, 32'd0);
        chk("re_idle_addr",  imem_addr,            32'h0);
        step();
        step();
        chk("re_e3_valid", {31'd0, if_id_valid}, 32'd1);
        step();
        step();
        step();
        stall_i = 1'b1;
        step();
        chk("drain_main", exp_q.size(),  32'd0);
        chk("drain_wrap", exp2_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
